// File: rtl/stack_arbiter_pkg.sv
// Shared encodings for the stack arbiter: FSM states and request op codes.
// Imported by the arbiter top and its round-robin picker.
package stack_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  // Round-robin pointer advance with wrap at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stack_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               any
);

  always_comb begin
    int cand;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = 0;
    // Walk from farthest to nearest so the nearest valid candidate wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (valid[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        gnt_idx   = PTR_W'(cand);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO stack between NUM_REQ requesters;
// one operation in flight, full/empty rejection, and a stack clear pulse.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          stk_push,
  output logic                          stk_pop,
  output logic [DATA_WIDTH-1:0]         stk_data,
  output logic                          stk_clr_n,
  input  logic [DATA_WIDTH-1:0]         stk_data_out,
  input  logic                          stk_full,
  input  logic                          stk_empty
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    stk_push_q, stk_push_d;
  logic                    stk_pop_q, stk_pop_d;
  logic [DATA_WIDTH-1:0]   stk_data_q, stk_data_d;
  logic                    stk_clr_n_q, stk_clr_n_d;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [PTR_W-1:0]        pick_idx;
  logic                    pick_any;
  logic                    sel_op;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    reject;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .valid   (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    sel_op   = req_op[pick_idx];
    sel_data = req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
    // Flags are only meaningful in IDLE, where the stack is quiescent.
    reject   = (sel_op == OP_PUSH && stk_full) || (sel_op == OP_POP && stk_empty);
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    stk_push_d  = 1'b0;
    stk_pop_d   = 1'b0;
    stk_data_d  = stk_data_q;
    stk_clr_n_d = 1'b1;
    req_ready   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (clr) begin
          stk_clr_n_d = 1'b0;
          state_d     = ST_CLEAR;
        end else if (pick_any) begin
          req_ready = pick_gnt;
          gnt_idx_d = pick_idx;
          rr_ptr_d  = PTR_W'(rr_next(int'(pick_idx), NUM_REQ));
          if (reject) begin
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_valid_d = pick_gnt;
            state_d     = ST_RESP;
          end else begin
            stk_push_d = (sel_op == OP_PUSH);
            stk_pop_d  = (sel_op == OP_POP);
            stk_data_d = sel_data;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        rsp_data_d  = stk_data_out;
        rsp_err_d   = 1'b0;
        rsp_valid_d = NUM_REQ'(1) << gnt_idx_q;
        state_d     = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      stk_data_q  <= '0;
      stk_clr_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      stk_push_q  <= stk_push_d;
      stk_pop_q   <= stk_pop_d;
      stk_data_q  <= stk_data_d;
      stk_clr_n_q <= stk_clr_n_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign stk_push  = stk_push_q;
  assign stk_pop   = stk_pop_q;
  assign stk_data  = stk_data_q;
  assign stk_clr_n = stk_clr_n_q;

endmodule
